tx_arbiter: RTL and testbench



---
 rtl/tx_arbiter_pkg.sv | 13 +
 rtl/rr_pick.sv | 31 +++
 rtl/tx_arbiter.sv | 119 +++++++++++
 tb/tb_tx_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter family.
package tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } arb_state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: returns the first set request
// bit found when searching upward from rr_ptr, wrapping modulo NUM_REQ.
module rr_pick
  import tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic               valid,
  output logic [IDW-1:0]     index
);

  function automatic logic [IDW-1:0] wrap_idx(input int base, input int offset);
    return IDW'((base + offset) % NUM_REQ);
  endfunction

  // Scan candidates in rotating order and keep the first active one.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!valid && req[wrap_idx(int'(rr_ptr), off)]) begin
        valid = 1'b1;
        index = wrap_idx(int'(rr_ptr), off);
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// producers. Drives the four-phase Send/Sent handshake and pulses ack to the
// granted requester once its byte has been accepted.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          tx_send,
  output logic [DATA_WIDTH-1:0]         tx_din,
  input  logic                          tx_sent,
  output logic                          busy,
  output logic [IDW-1:0]                grant_id
);

  arb_state_t             state, state_next;
  logic [IDW-1:0]         rr_ptr, rr_ptr_next;
  logic [IDW-1:0]         grant_next;
  logic [DATA_WIDTH-1:0]  din_next;
  logic                   send_next;
  logic [NUM_REQ-1:0]     ack_next;
  logic                   busy_next;

  logic                   pick_valid;
  logic [IDW-1:0]         pick_index;
  logic [DATA_WIDTH-1:0]  pick_byte;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .valid   (pick_valid),
    .index   (pick_index)
  );

  // Select the byte belonging to the requester the encoder would grant.
  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_index == IDW'(i)) begin
        pick_byte = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state and next-output logic; every output is computed here and
  // registered below so nothing combinational reaches the ports.
  always_comb begin
    state_next  = state;
    rr_ptr_next = rr_ptr;
    grant_next  = grant_id;
    din_next    = tx_din;
    send_next   = tx_send;
    ack_next    = '0;
    case (state)
      IDLE: begin
        if (!tx_sent && pick_valid) begin
          din_next   = pick_byte;
          grant_next = pick_index;
          send_next  = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (tx_sent) begin
          ack_next[grant_id] = 1'b1;
          send_next          = 1'b0;
          state_next         = RELEASE;
        end
      end
      RELEASE: begin
        if (!tx_sent) begin
          if (int'(grant_id) == NUM_REQ - 1) begin
            rr_ptr_next = '0;
          end else begin
            rr_ptr_next = grant_id + IDW'(1);
          end
          state_next = IDLE;
        end
      end
      default: begin
        send_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // State and output registers; reset aborts any transfer without an ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      tx_din   <= '0;
      tx_send  <= 1'b0;
      ack      <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      rr_ptr   <= rr_ptr_next;
      grant_id <= grant_next;
      tx_din   <= din_next;
      tx_send  <= send_next;
      ack      <= ack_next;
      busy     <= busy_next;
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: a tx handshake model, a requester model
// that reacts to ack, a vector table for arbitration order, and hand-written
// sequences for reset and data-capture corner cases.
module tb_tx_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DW         = 8;
  localparam int IDW        = 2;
  localparam int SENT_DELAY = 10;
  localparam int TIMEOUT    = 200;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ*DW-1:0] req_data = '0;
  logic [NUM_REQ-1:0]    ack;
  logic                  tx_send;
  logic [DW-1:0]         tx_din;
  logic                  tx_sent = 1'b0;
  logic                  busy;
  logic [IDW-1:0]        grant_id;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int fall_cycle = 0;
  int sent_cnt = 0;
  int remaining[NUM_REQ];
  logic [NUM_REQ-1:0] inc_mask = '0;

  typedef struct {
    bit          do_reset;
    logic [3:0]  start_req;
    logic [31:0] start_data;
    logic [15:0] start_cnt;
    logic [3:0]  inc;
    int          exp_grant;
    logic [7:0]  exp_din;
    bit          gap;
  } vec_t;

  vec_t vecs[11];

  tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .IDW        (IDW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .tx_send  (tx_send),
    .tx_din   (tx_din),
    .tx_sent  (tx_sent),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Transmitter model: raise Sent SENT_DELAY cycles after Send, drop it one
  // cycle after Send falls.
  initial forever begin
    @(posedge clk);
    #1;
    if (reset) begin
      tx_sent  = 1'b0;
      sent_cnt = 0;
    end else if (tx_send && !tx_sent) begin
      sent_cnt++;
      if (sent_cnt == SENT_DELAY) begin
        tx_sent  = 1'b1;
        sent_cnt = 0;
      end
    end else if (!tx_send && tx_sent) begin
      tx_sent    = 1'b0;
      fall_cycle = cycle;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out after %0d cycles (cycle %0d)", name, TIMEOUT, cycle);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Requester reaction to an ack: drop req after the last byte, else present
  // the next byte (or the same byte again) with req kept high.
  task automatic requesterUpdate();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack[i]) begin
        remaining[i]--;
        if (remaining[i] <= 0) req[i] = 1'b0;
        else if (inc_mask[i]) req_data[i*DW +: DW] = req_data[i*DW +: DW] + 8'h01;
      end
    end
  endtask

  task automatic waitSend(output bit ok);
    int n = 0;
    while (!tx_send && n < TIMEOUT) begin
      tick();
      n++;
    end
    ok = tx_send;
    if (!ok) reportTimeout("wait_tx_send");
  endtask

  task automatic waitAck(output bit ok);
    int n = 0;
    while (ack == '0 && n < TIMEOUT) begin
      tick();
      n++;
    end
    ok = (ack != '0);
    if (!ok) reportTimeout("wait_ack");
  endtask

  // One complete transfer: grant, byte, optional spacing check, ack pulse.
  task automatic waitTransfer(input int exp_grant, input logic [7:0] exp_din, input bit gap);
    bit ok;
    waitSend(ok);
    if (!ok) return;
    checkOutput("grant_id", 32'(grant_id), 32'(exp_grant));
    checkOutput("tx_din", 32'(tx_din), 32'(exp_din));
    checkOutput("busy_on_grant", 32'(busy), 32'd1);
    if (gap) checkOutput("idle_gap", 32'((cycle - fall_cycle) >= 2), 32'd1);
    waitAck(ok);
    if (!ok) return;
    checkOutput("ack", 32'(ack), 32'(4'b0001 << exp_grant));
    requesterUpdate();
    tick();
    checkOutput("ack_one_cycle", 32'(ack), 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    int n = 0;
    if (v.do_reset) doReset();
    while (busy && n < TIMEOUT) begin
      tick();
      n++;
    end
    if (busy) reportTimeout("wait_idle");
    for (int i = 0; i < NUM_REQ; i++) remaining[i] = int'(v.start_cnt[i*4 +: 4]);
    inc_mask = v.inc;
    req_data = v.start_data;
    req      = v.start_req;
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;

    vecs[0]  = '{1'b1, 4'b1111, 32'h33323130, 16'h1112, 4'b0000, 0, 8'h30, 1'b0};
    vecs[1]  = '{1'b0, 4'b0000, 32'h0,        16'h0,    4'b0000, 1, 8'h31, 1'b1};
    vecs[2]  = '{1'b0, 4'b0000, 32'h0,        16'h0,    4'b0000, 2, 8'h32, 1'b1};
    vecs[3]  = '{1'b0, 4'b0000, 32'h0,        16'h0,    4'b0000, 3, 8'h33, 1'b1};
    vecs[4]  = '{1'b0, 4'b0000, 32'h0,        16'h0,    4'b0000, 0, 8'h30, 1'b1};
    vecs[5]  = '{1'b0, 4'b0100, 32'h00A00000, 16'h0300, 4'b0100, 2, 8'hA0, 1'b0};
    vecs[6]  = '{1'b0, 4'b0000, 32'h0,        16'h0,    4'b0000, 2, 8'hA1, 1'b1};
    vecs[7]  = '{1'b0, 4'b0000, 32'h0,        16'h0,    4'b0000, 2, 8'hA2, 1'b1};
    vecs[8]  = '{1'b0, 4'b0010, 32'h00001100, 16'h0010, 4'b0000, 1, 8'h11, 1'b0};
    vecs[9]  = '{1'b0, 4'b0011, 32'h00002233, 16'h0011, 4'b0000, 0, 8'h33, 1'b0};
    vecs[10] = '{1'b0, 4'b0000, 32'h0,        16'h0,    4'b0000, 1, 8'h22, 1'b1};

    // Reset values.
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_tx_send", 32'(tx_send), 32'd0);
    checkOutput("rst_tx_din", 32'(tx_din), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
    reset = 1'b0;
    tick();

    // Single byte from requester 0; Send must rise one clock after req.
    remaining[0] = 1;
    inc_mask = '0;
    req_data[7:0] = 8'h41;
    req = 4'b0001;
    tick();
    checkOutput("first_send_latency", 32'(tx_send), 32'd1);
    waitTransfer(0, 8'h41, 1'b0);
    checkOutput("busy_after_release", 32'(busy), 32'd0);

    // Table-driven arbitration order: rotation, back-to-back, wraparound.
    for (int k = 0; k < 11; k++) begin
      if (vecs[k].start_req != '0 || vecs[k].do_reset) applyStimulus(vecs[k]);
      waitTransfer(vecs[k].exp_grant, vecs[k].exp_din, vecs[k].gap);
    end

    // Asynchronous reset during SEND, then a fresh grant to the held request.
    tick();
    remaining[2] = 1;
    inc_mask = '0;
    req_data = '0;
    req_data[23:16] = 8'h5A;
    req = 4'b0100;
    waitSend(ok);
    repeat (3) tick();
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_tx_send", 32'(tx_send), 32'd0);
    checkOutput("async_ack", 32'(ack), 32'd0);
    checkOutput("async_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    waitTransfer(2, 8'h5A, 1'b0);

    // Byte is captured at grant; later req_data changes are ignored.
    tick();
    remaining[1] = 1;
    req_data[15:8] = 8'h55;
    req = 4'b0010;
    waitSend(ok);
    if (ok) begin
      int n = 0;
      checkOutput("capture_grant", 32'(grant_id), 32'd1);
      req_data[15:8] = 8'hAA;
      while (ack == '0 && n < TIMEOUT) begin
        if (tx_send) checkOutput("capture_hold", 32'(tx_din), 32'h55);
        tick();
        n++;
      end
      if (ack == '0) reportTimeout("capture_ack");
      else begin
        checkOutput("capture_ack", 32'(ack), 32'b0010);
        requesterUpdate();
        tick();
        checkOutput("capture_ack_one_cycle", 32'(ack), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
